// File: rtl/ddram_rd_dma_pkg.sv
// ddram_pkg: shared DDR requestor-port widths and the read-DMA state encoding.
package ddram_pkg;
    localparam int DDR_ADDR_W = 29;
    localparam int DDR_DATA_W = 64;
    localparam int DDR_BURST_W = 8;
    typedef enum logic [2:0] {S_IDLE, S_SPACE, S_REQ, S_DATA, S_DRAIN, S_FINISH} rd_dma_state_e;
endpackage

// File: rtl/ddram_rd_dma_if.sv
// ddram_rd_dma_if: command, DDR read-port and output-stream signals of the read DMA.
interface ddram_rd_dma_if;
    import ddram_pkg::*;
    logic cmd_valid, cmd_ready;
    logic [DDR_ADDR_W-1:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [DDR_ADDR_W-1:0] rd_addr;
    logic [DDR_BURST_W-1:0] rd_burstcnt;
    logic rd_req, rd_ack, rd_data_valid;
    logic [DDR_DATA_W-1:0] rd_data;
    logic out_valid, out_ready, out_last;
    logic [DDR_DATA_W-1:0] out_data;
    logic busy, done;
    modport slave (
        input cmd_valid, cmd_addr, cmd_len, rd_ack, rd_data, rd_data_valid, out_ready,
        output cmd_ready, rd_addr, rd_burstcnt, rd_req, out_valid, out_data, out_last, busy, done
    );
    modport master (
        output cmd_valid, cmd_addr, cmd_len, rd_ack, rd_data, rd_data_valid, out_ready,
        input cmd_ready, rd_addr, rd_burstcnt, rd_req, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/ddram_rd_dma_stream_fifo.sv
// ddram_stream_fifo: synchronous FIFO, head visible the cycle after its write, with occupancy and flush.
module ddram_stream_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [W-1:0]              wr_data,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [W-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic pop;
    assign rd_valid = count != '0;
    assign rd_data = mem[rp];
    assign pop = rd_en && rd_valid;
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= wr_data;
        if (reset || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(wr_en);
            rp <= rp + AW'(pop);
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end
endmodule

// File: rtl/ddram_rd_dma.sv
// ddram_rd_dma: splits a linear read command into single-outstanding DDR bursts and streams the beats out.
// Define DDRAM_RD_DMA_BOUNDARY_EN to keep every burst inside one BOUNDARY_WORDS-aligned line.
module ddram_rd_dma
    import ddram_pkg::*;
#(
    parameter int MAX_BURST = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int BOUNDARY_WORDS = 512
) (
    input logic clk,
    input logic reset,
    ddram_rd_dma_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BOUNDARY_WORDS);
    localparam logic [BW:0] LINE = BOUNDARY_WORDS[BW:0];
`ifdef DDRAM_RD_DMA_BOUNDARY_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    rd_dma_state_e state, state_nx;
    logic [DDR_ADDR_W-1:0] addr;
    logic [15:0] remaining, popped, last_idx;
    logic [DDR_BURST_W-1:0] beats, burst, b_len;
    logic [BW:0] room;
    logic [CW-1:0] count, occ_next;
    logic accept, wr_en, pop, last_beat, fits;
    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign wr_en = state == S_DATA && bus.rd_data_valid;
    assign pop = bus.out_valid && bus.out_ready;
    assign last_beat = wr_en && beats == DDR_BURST_W'(1);
    assign b_len = remaining < 16'(MAX_BURST) ? remaining[DDR_BURST_W-1:0] : DDR_BURST_W'(MAX_BURST);
    assign room = LINE - {1'b0, addr[BW-1:0]};
    assign burst = CLAMP && int'(room) < int'(b_len) ? DDR_BURST_W'(room) : b_len;
    // The DDR return path cannot stall, so space is judged on next-cycle occupancy.
    assign occ_next = count + CW'(wr_en) - CW'(pop);
    assign fits = int'(occ_next) + int'(burst) <= FIFO_DEPTH;
    assign bus.busy = state != S_IDLE;
    assign bus.cmd_ready = state == S_IDLE && !reset;
    assign bus.rd_req = state == S_REQ;
    assign bus.rd_addr = addr;
    assign bus.rd_burstcnt = burst;
    assign bus.done = state == S_FINISH;
    assign bus.out_last = bus.out_valid && popped == last_idx;
    always_ff @(posedge clk)
        if (reset) state <= S_IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = bus.cmd_len == 16'd0 ? S_FINISH : S_REQ;
            S_SPACE: if (fits) state_nx = S_REQ;
            S_REQ:   if (bus.rd_ack) state_nx = S_DATA;
            S_DATA:  if (last_beat) state_nx = remaining == 16'd0 ? S_DRAIN : fits ? S_REQ : S_SPACE;
            S_DRAIN: if (pop && bus.out_last) state_nx = S_FINISH;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (reset) begin
            addr <= '0;
            remaining <= '0;
            popped <= '0;
            last_idx <= '0;
            beats <= '0;
        end else begin
            if (accept) begin
                addr <= bus.cmd_addr;
                remaining <= bus.cmd_len;
                popped <= '0;
                last_idx <= bus.cmd_len - 16'd1;
            end
            if (state == S_REQ && bus.rd_ack) begin
                addr <= addr + DDR_ADDR_W'(burst);
                remaining <= remaining - 16'(burst);
                beats <= burst;
            end else if (wr_en) beats <= beats - DDR_BURST_W'(1);
            if (pop) popped <= popped + 16'd1;
        end
    ddram_stream_fifo #(.W(DDR_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .flush(accept),
        .wr_en(wr_en),
        .wr_data(bus.rd_data),
        .rd_en(bus.out_ready),
        .rd_valid(bus.out_valid),
        .rd_data(bus.out_data),
        .count(count)
    );
endmodule

// File: tb/tb_ddram_rd_dma.sv
// tb_ddram_rd_dma: directed tests against a queue-based model of bursts, occupancy and the output stream.
module tb_ddram_rd_dma;
    import ddram_pkg::*;
    localparam int MAXB = 32;
    localparam int DEPTH = 64;
    localparam int BWORDS = 512;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    ddram_rd_dma_if bus();
    ddram_rd_dma #(.MAX_BURST(MAXB), .FIFO_DEPTH(DEPTH), .BOUNDARY_WORDS(BWORDS)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    int n_chk = 0, n_pass = 0;
    int ack_delay = 0, stray_cap = -1;
    int cyc = 0, occ = 0, beats_left = 0, pidx = 0, m_len = 0;
    int done_at = -1, first_req_at = -1, done_cnt = 0, words_out = 0, beats_in = 0, req_cycles = 0;
    bit busy_m = 1'b0, ack_prev = 1'b0, req_prev = 1'b0;
    logic [28:0] m_base = '0;
    logic [28:0] reqq_a[$], log_a[$];
    int reqq_n[$], log_n[$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endfunction

    function automatic logic [63:0] word_of(input logic [28:0] a);
        return {a, 6'h2A, ~a};
    endfunction

    // Expected burst list straight from the min() rule.
    function automatic void plan(input logic [28:0] a, input int len);
        int r, b;
        r = len;
        reqq_a.delete();
        reqq_n.delete();
        while (r > 0) begin
            b = r < MAXB ? r : MAXB;
`ifdef DDRAM_RD_DMA_BOUNDARY_EN
            if (BWORDS - int'(a % BWORDS) < b) b = BWORDS - int'(a % BWORDS);
`endif
            reqq_a.push_back(a);
            reqq_n.push_back(b);
            a = a + 29'(b);
            r -= b;
        end
    endfunction

    // DDR responder: ack after ack_delay cycles, then return the burst beats back to back.
    initial begin
        logic [28:0] a;
        int n;
        bus.rd_ack = 1'b0;
        bus.rd_data_valid = 1'b0;
        bus.rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.rd_req && !reset) begin
                a = bus.rd_addr;
                n = int'(bus.rd_burstcnt);
                repeat (ack_delay) begin @(posedge clk); #1; end
                bus.rd_ack = 1'b1;
                @(posedge clk); #1;
                bus.rd_ack = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                for (int i = 0; i < n; i++) begin
                    if (stray_cap == 0) break;
                    bus.rd_data_valid = 1'b1;
                    bus.rd_data = word_of(a + 29'(i));
                    @(posedge clk); #1;
                    if (stray_cap > 0) stray_cap--;
                end
                bus.rd_data_valid = 1'b0;
            end
        end
    end

    // Model and per-cycle compare.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                occ = 0;
                beats_left = 0;
                reqq_a.delete();
                reqq_n.delete();
                busy_m = 1'b0;
                done_at = -1;
                first_req_at = -1;
                ack_prev = 1'b0;
                req_prev = 1'b0;
                continue;
            end
            chk("busy", bus.busy, busy_m);
            chk("cmd_ready", bus.cmd_ready, !busy_m);
            chk("done", bus.done, cyc == done_at);
            chk("out_valid", bus.out_valid, occ > 0);
            if (bus.out_valid && occ > 0) begin
                chk("out_data", bus.out_data, word_of(m_base + 29'(pidx)));
                chk("out_last", bus.out_last, pidx == m_len - 1);
            end
            if (cyc == first_req_at) chk("req_at_t1", bus.rd_req, 1'b1);
            if (ack_prev) chk("req_drop_after_ack", bus.rd_req, 1'b0);
            if (bus.rd_req) begin
                req_cycles++;
                chk("req_expected", reqq_a.size() > 0, 1'b1);
                chk("one_outstanding", beats_left, 0);
                if (reqq_a.size() > 0) begin
                    chk("rd_addr", bus.rd_addr, reqq_a[0]);
                    chk("rd_burstcnt", bus.rd_burstcnt, reqq_n[0]);
                    if (!req_prev) chk("space_ok", occ + reqq_n[0] <= DEPTH, 1'b1);
                end
            end
            ack_prev = bus.rd_req && bus.rd_ack;
            req_prev = bus.rd_req;
            if (cyc == done_at) begin
                busy_m = 1'b0;
                done_cnt++;
            end
            if (bus.rd_req && bus.rd_ack && reqq_a.size() > 0) begin
                log_a.push_back(reqq_a[0]);
                log_n.push_back(reqq_n[0]);
                beats_left = reqq_n[0];
                void'(reqq_a.pop_front());
                void'(reqq_n.pop_front());
            end
            if (bus.rd_data_valid && beats_left > 0) begin
                occ++;
                beats_left--;
                beats_in++;
            end
            if (bus.out_valid && bus.out_ready && occ > 0) begin
                occ--;
                if (pidx == m_len - 1) done_at = cyc + 1;
                pidx++;
                words_out++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                busy_m = 1'b1;
                m_base = bus.cmd_addr;
                m_len = int'(bus.cmd_len);
                pidx = 0;
                plan(bus.cmd_addr, int'(bus.cmd_len));
                if (bus.cmd_len == 16'd0) done_at = cyc + 1;
                else first_req_at = cyc + 1;
            end
        end
    end

    task automatic issue(input logic [28:0] a, input logic [15:0] l);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr = a;
        bus.cmd_len = l;
        @(negedge clk);
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        chk("done_reached", done_cnt, target);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lb, w0, d0, b0, r0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_rd_req", bus.rd_req, 1'b0);
        chk("rst_rd_addr", bus.rd_addr, 29'h0);
        chk("rst_rd_burstcnt", bus.rd_burstcnt, 8'h0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);

        // 70 words from 0x100
        lb = log_a.size(); w0 = words_out; d0 = done_cnt;
        issue(29'h100, 16'd70);
        wait_done(d0 + 1, 400);
        chk("t1_nreq", log_a.size() - lb, 3);
        if (log_a.size() - lb == 3) begin
            chk("t1_a0", log_a[lb], 29'h100);   chk("t1_n0", log_n[lb], 32);
            chk("t1_a1", log_a[lb+1], 29'h120); chk("t1_n1", log_n[lb+1], 32);
            chk("t1_a2", log_a[lb+2], 29'h140); chk("t1_n2", log_n[lb+2], 6);
        end
        chk("t1_words", words_out - w0, 70);

        // zero length
        lb = log_a.size(); d0 = done_cnt;
        issue(29'h500, 16'd0);
        wait_done(d0 + 1, 20);
        chk("t2_no_req", log_a.size() - lb, 0);

        // consumer stalled: only two bursts fit
        bus.out_ready = 1'b0;
        lb = log_a.size(); w0 = words_out; d0 = done_cnt;
        issue(29'h1000, 16'd200);
        repeat (200) @(negedge clk);
        chk("t3_stalled_nreq", log_a.size() - lb, 2);
        chk("t3_stalled_occ", occ, 64);
        chk("t3_stalled_valid", bus.out_valid, 1'b1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_done(d0 + 1, 800);
        chk("t3_nreq", log_a.size() - lb, 7);
        if (log_a.size() - lb == 7) begin
            chk("t3_a6", log_a[lb+6], 29'h10C0);
            chk("t3_n6", log_n[lb+6], 8);
        end
        chk("t3_words", words_out - w0, 200);

        // boundary-adjacent start
        lb = log_a.size(); d0 = done_cnt;
        issue(29'h1F0, 16'd40);
        wait_done(d0 + 1, 300);
        chk("t4_nreq", log_a.size() - lb, 2);
        if (log_a.size() - lb == 2) begin
`ifdef DDRAM_RD_DMA_BOUNDARY_EN
            chk("t4_a0", log_a[lb], 29'h1F0);   chk("t4_n0", log_n[lb], 16);
            chk("t4_a1", log_a[lb+1], 29'h200); chk("t4_n1", log_n[lb+1], 24);
`else
            chk("t4_a0", log_a[lb], 29'h1F0);   chk("t4_n0", log_n[lb], 32);
            chk("t4_a1", log_a[lb+1], 29'h210); chk("t4_n1", log_n[lb+1], 8);
`endif
        end

        // slow ack: request held 21 cycles
        ack_delay = 20;
        d0 = done_cnt; r0 = req_cycles;
        issue(29'h2000, 16'd10);
        wait_done(d0 + 1, 200);
        chk("t5_req_cycles", req_cycles - r0, 21);
        ack_delay = 0;

        // reset mid-burst, then stray beats
        d0 = done_cnt; b0 = beats_in;
        issue(29'h40, 16'd100);
        for (int i = 0; i < 200 && beats_in < b0 + 3; i++) @(negedge clk);
        chk("t6_beats_before_reset", beats_in - b0 >= 3, 1'b1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        stray_cap = 5;
        chk("t6_rst_rd_req", bus.rd_req, 1'b0);
        chk("t6_rst_rd_addr", bus.rd_addr, 29'h0);
        chk("t6_rst_burstcnt", bus.rd_burstcnt, 8'h0);
        chk("t6_rst_out_valid", bus.out_valid, 1'b0);
        chk("t6_rst_busy", bus.busy, 1'b0);
        repeat (20) @(negedge clk);
        chk("t6_fifo_empty", dut.u_fifo.count, 0);
        chk("t6_no_stray_out", bus.out_valid, 1'b0);
        stray_cap = -1;
        lb = log_a.size(); w0 = words_out; d0 = done_cnt;
        issue(29'h300, 16'd5);
        wait_done(d0 + 1, 200);
        chk("t6_nreq", log_a.size() - lb, 1);
        if (log_a.size() - lb == 1) begin
            chk("t6_a0", log_a[lb], 29'h300);
            chk("t6_n0", log_n[lb], 5);
        end
        chk("t6_words", words_out - w0, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want summary before timeout");
        $fatal(1);
    end
endmodule
